// File: rtl/urv_writeback_lsu.sv
// uRV writeback stage: load alignment, memory completion wait, rf write port.
// Optional access timeout enabled with `URV_WB_LOAD_TIMEOUT_EN.
module urv_writeback_lsu #(
  parameter int g_load_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic        x_valid_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LD,
    WAIT_ST
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  l_rd;
  logic [2:0]  l_fun;
  logic [1:0]  l_addr;
  logic        l_rd_write;
  logic        accept;
  logic        ld_pend;
  logic        st_pend;
  logic        timeout;
  logic        cmp_en;
  logic        cmp_wr;
  logic [4:0]  cmp_rd;
  logic [31:0] cmp_val;
  logic        abort;
  logic        unused;

  assign unused = ^x_dm_addr_i[31:2];

  function automatic logic [31:0] load_align(
    input logic [2:0]  fun,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (fun)
      3'b000:  load_align = {{24{b[7]}}, b};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b100:  load_align = {24'd0, b};
      3'b101:  load_align = {16'd0, h};
      default: load_align = d;
    endcase
  endfunction

  assign accept  = x_valid_i && !w_stall_i;
  assign ld_pend = accept && x_load_i && !dm_load_done_i;
  assign st_pend = accept && !x_load_i && x_store_i && !dm_store_done_i;

`ifdef URV_WB_LOAD_TIMEOUT_EN
  // Accept cycle plus waiting cycles add up to g_load_timeout stall cycles.
  localparam logic [31:0] TO_LAST =
    (g_load_timeout > 2) ? 32'(g_load_timeout - 2) : 32'd0;
  logic [15:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      to_cnt <= '0;
    else if (state == IDLE)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 16'd1;
  end

  assign timeout = (state != IDLE) && ({16'd0, to_cnt} >= TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ld_pend)
          state_nxt = WAIT_LD;
        else if (st_pend)
          state_nxt = WAIT_ST;
      end
      WAIT_LD:
        if (dm_load_done_i || timeout)
          state_nxt = IDLE;
      WAIT_ST:
        if (dm_store_done_i || timeout)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_stall_req_o = 1'b0;
    cmp_en        = 1'b0;
    cmp_wr        = 1'b0;
    abort         = 1'b0;
    cmp_rd        = x_rd_i;
    unique case (x_rd_source_i)
      2'b00:   cmp_val = x_rd_value_i;
      2'b01:   cmp_val = load_align(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
      2'b10:   cmp_val = x_shifter_rd_value_i;
      default: cmp_val = x_multiply_rd_value_i;
    endcase
    unique case (state)
      IDLE: begin
        if (ld_pend || st_pend) begin
          w_stall_req_o = 1'b1;
        end else if (accept) begin
          cmp_en = 1'b1;
          cmp_wr = x_rd_write_i && (x_rd_i != 5'd0);
        end
      end
      WAIT_LD: begin
        if (dm_load_done_i) begin
          cmp_en  = 1'b1;
          cmp_rd  = l_rd;
          cmp_val = load_align(l_fun, l_addr, dm_data_l_i);
          cmp_wr  = l_rd_write && (l_rd != 5'd0);
        end else begin
          w_stall_req_o = 1'b1;
          abort         = timeout;
        end
      end
      WAIT_ST: begin
        if (!dm_store_done_i) begin
          w_stall_req_o = 1'b1;
          abort         = timeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l_rd       <= '0;
      l_fun      <= '0;
      l_addr     <= '0;
      l_rd_write <= 1'b0;
    end else if (state == IDLE && ld_pend) begin
      l_rd       <= x_rd_i;
      l_fun      <= x_fun_i;
      l_addr     <= x_dm_addr_i[1:0];
      l_rd_write <= x_rd_write_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_rd_o       <= '0;
      rf_rd_value_o <= '0;
      rf_rd_write_o <= 1'b0;
      w_bus_err_o   <= 1'b0;
    end else begin
      rf_rd_write_o <= cmp_en && cmp_wr;
      w_bus_err_o   <= abort;
      if (cmp_en) begin
        rf_rd_o       <= cmp_rd;
        rf_rd_value_o <= cmp_val;
      end
    end
  end

endmodule
